// File: rtl/chip_inv_pkg.sv
// Shared definitions for the invader formation logic: screen and grid
// geometry, the on-screen position type and the march controller states.
package chip_inv_pkg;

  localparam int unsigned SCREEN_W      = 640;
  localparam int unsigned ALIEN_W       = 10;
  localparam int unsigned ALIEN_SPACING = 10;
  localparam int unsigned GRID_COLS     = 11;
  localparam int unsigned GRID_ROWS     = 5;
  localparam int unsigned MAX_ALIENS    = 55;

  typedef logic [9:0] pos_t;

  typedef enum logic [1:0] {
    IDLE,
    MARCH,
    CLEARED,
    INVADED
  } march_state_t;

endpackage

// File: rtl/march_period_gen.sv
// Frames-per-step generator for the formation march.
// Build option MARCH_SPEEDUP_EN: when defined the period shrinks with the
// live alien count, max(MIN_PERIOD, alive*BASE_PERIOD/MAX_ALIENS); when
// undefined the period is the fixed BASE_PERIOD.
module march_period_gen
  import chip_inv_pkg::*;
#(
  parameter int unsigned BASE_PERIOD = 32,
  parameter int unsigned MIN_PERIOD  = 2
) (
  input  logic [5:0] alive_count_i,
  output logic [6:0] period_o
);

`ifdef MARCH_SPEEDUP_EN
  logic [12:0] scaled;

  // Scale the base period by the surviving fraction of the formation, floored at MIN_PERIOD.
  always_comb begin
    scaled = (13'(alive_count_i) * 13'(BASE_PERIOD)) / 13'(MAX_ALIENS);
    if (scaled < 13'(MIN_PERIOD)) begin
      period_o = 7'(MIN_PERIOD);
    end else begin
      period_o = scaled[6:0];
    end
  end
`else
  logic unused_alive;
  assign unused_alive = ^alive_count_i;

  // Fixed march speed regardless of how many aliens remain.
  always_comb begin
    if (BASE_PERIOD < MIN_PERIOD) begin
      period_o = 7'(MIN_PERIOD);
    end else begin
      period_o = 7'(BASE_PERIOD);
    end
  end
`endif

endmodule

// File: rtl/alien_march_ctrl.sv
// Formation march controller: steps the alien formation every period
// frames, drops and reverses it at the screen edges and flags invasion
// once the formation reaches the player row.
// Build option MARCH_SPEEDUP_EN (see march_period_gen) speeds up the march
// as aliens die.
module alien_march_ctrl
  import chip_inv_pkg::*;
#(
  parameter int unsigned SCREEN_W    = 640,
  parameter int unsigned STEP_X      = 2,
  parameter int unsigned STEP_Y      = 10,
  parameter int unsigned Y_LIMIT     = 400,
  parameter int unsigned BASE_PERIOD = 32,
  parameter int unsigned MIN_PERIOD  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       enable,
  input  logic [5:0] alive_count,
  input  logic [9:0] left_edge,
  input  logic [9:0] right_edge,
  output logic       dir,
  output logic [9:0] x_off,
  output logic [9:0] y_off,
  output logic       step,
  output logic       drop,
  output logic       invaded
);

  march_state_t state_q, state_d;
  logic [6:0]   frame_cnt_q, frame_cnt_d;
  logic         dir_q, dir_d;
  pos_t         x_off_q, x_off_d;
  pos_t         y_off_q, y_off_d;
  logic         step_q, step_d;
  logic         drop_q, drop_d;
  logic         invaded_q, invaded_d;

  logic [6:0]   period;
  logic [10:0]  right_reach;
  logic         hit_edge;
  pos_t         y_next;

  march_period_gen #(
    .BASE_PERIOD (BASE_PERIOD),
    .MIN_PERIOD  (MIN_PERIOD)
  ) u_period (
    .alive_count_i (alive_count),
    .period_o      (period)
  );

  // State and output registers; reset returns the formation to its home position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      frame_cnt_q <= '0;
      dir_q       <= 1'b1;
      x_off_q     <= '0;
      y_off_q     <= '0;
      step_q      <= 1'b0;
      drop_q      <= 1'b0;
      invaded_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      dir_q       <= dir_d;
      x_off_q     <= x_off_d;
      y_off_q     <= y_off_d;
      step_q      <= step_d;
      drop_q      <= drop_d;
      invaded_q   <= invaded_d;
    end
  end

  // Next-state logic: alive check beats invasion beats enable beats the frame-driven move.
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    dir_d       = dir_q;
    x_off_d     = x_off_q;
    y_off_d     = y_off_q;
    step_d      = 1'b0;
    drop_d      = 1'b0;
    invaded_d   = invaded_q;

    right_reach = {1'b0, right_edge} + 11'(STEP_X);
    hit_edge    = dir_q ? (right_reach > 11'(SCREEN_W - 1))
                        : (left_edge < 10'(STEP_X));
    y_next      = y_off_q + 10'(STEP_Y);

    case (state_q)
      IDLE: begin
        if (enable) state_d = MARCH;
      end
      MARCH: begin
        if (alive_count == '0) begin
          state_d = CLEARED;
        end else if (y_off_q >= 10'(Y_LIMIT)) begin
          invaded_d = 1'b1;
          state_d   = INVADED;
        end else if (!enable) begin
          state_d = IDLE;
        end else if (frame_tick) begin
          if (frame_cnt_q >= period - 7'd1) begin
            frame_cnt_d = '0;
            if (hit_edge) begin
              y_off_d = y_next;
              dir_d   = ~dir_q;
              drop_d  = 1'b1;
              if (y_next >= 10'(Y_LIMIT)) begin
                invaded_d = 1'b1;
                state_d   = INVADED;
              end
            end else begin
              x_off_d = dir_q ? x_off_q + 10'(STEP_X) : x_off_q - 10'(STEP_X);
              step_d  = 1'b1;
            end
          end else begin
            frame_cnt_d = frame_cnt_q + 7'd1;
          end
        end
      end
      CLEARED: begin
        if (alive_count != '0) state_d = MARCH;
      end
      INVADED: begin
        state_d = INVADED;
      end
      default: state_d = IDLE;
    endcase
  end

  assign dir     = dir_q;
  assign x_off   = x_off_q;
  assign y_off   = y_off_q;
  assign step    = step_q;
  assign drop    = drop_q;
  assign invaded = invaded_q;

endmodule

// File: doc/alien_march_ctrl.md
Name: alien_march_ctrl

Overview:
Formation march controller that sits directly upstream of the per-alien instances. It produces the shared direction flag and the formation x/y offsets that every alien adds to its grid position. It steps the formation once every N video frames and drops and reverses it at the screen edges. It reports invasion when the formation reaches the player row.

Parameters:
SCREEN_W, 640, visible width in pixels; right bound is SCREEN_W-1
STEP_X, 2, horizontal pixels per step
STEP_Y, 10, vertical pixels per drop
Y_LIMIT, 400, y_off value at or above which the formation has invaded
BASE_PERIOD, 32, frames per step with a full formation, or fixed period when the speed-up feature is off
MIN_PERIOD, 2, lowest frames-per-step value

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
frame_tick  in  1  one-cycle pulse per video frame
enable  in  1  game running; low freezes all motion
alive_count  in  6  number of live aliens, 0..55
left_edge  in  10  smallest on-screen x of any live alien, offset already applied
right_edge  in  10  largest on-screen x+width-1 of any live alien, offset already applied
dir  out  1  0 = left, 1 = right; feeds each alien's dir
x_off  out  10  unsigned formation x offset
y_off  out  10  unsigned formation y offset
step  out  1  one-cycle pulse on each horizontal move
drop  out  1  one-cycle pulse on each drop-and-reverse
invaded  out  1  sticky invasion flag

Behaviour:
- Reset values: dir=1, x_off=0, y_off=0, step=0, drop=0, invaded=0, frame_cnt=0, state IDLE. Reset mid-operation restores all of these asynchronously.
- States:
  - IDLE: waits for enable=1, then goes to MARCH.
  - MARCH: normal operation.
  - INVADED: terminal; only reset leaves it.
  - CLEARED: entered when alive_count==0; returns to MARCH when alive_count>0 again (next wave).
  - enable=0 in MARCH returns to IDLE. The offsets and frame_cnt are held, not cleared.
- In MARCH, on each frame_tick:
  - If frame_cnt >= period-1, then frame_cnt<=0 and a move event fires.
  - Otherwise frame_cnt increments.
  - frame_cnt is 7 bits.
- Move event, decided from the edge inputs sampled in the same cycle:
  - dir=1 and right_edge+STEP_X > SCREEN_W-1 is a drop: y_off += STEP_Y, dir toggles, x_off unchanged, drop pulses.
  - dir=0 and left_edge < STEP_X is a drop, handled the same way.
  - Otherwise x_off += STEP_X (dir=1) or x_off -= STEP_X (dir=0), and step pulses.
  - step and drop are never high together.
- Outputs are registered. dir, x_off, y_off and step/drop update on the clock edge after the frame_tick cycle that triggered the move (one-cycle latency).
- Invasion: after a drop, if the new y_off >= Y_LIMIT, then invaded<=1 in the same cycle as drop and the next state is INVADED. No further moves occur.
- Precedence when several conditions hold in the same cycle: reset, then alive_count==0, then invasion, then enable=0, then move event.
- frame_tick while not in MARCH is ignored.
- Edge inputs are trusted to be consistent with the current x_off. The block does not clamp x_off; the edge check guarantees it never wraps below 0.

Optional Feature:
MARCH_SPEEDUP_EN
- Defined: period = max(MIN_PERIOD, (alive_count*BASE_PERIOD)/55). The division is a 55-entry constant lookup or a shift approximation, exact to within ±1 frame. The formation accelerates as aliens die.
- Undefined: period = BASE_PERIOD always. alive_count is used only for the CLEARED detection.

Decomposition:
- Shared package chip_inv_pkg holds:
  - SCREEN_W, ALIEN_W (10), ALIEN_SPACING (10), GRID_COLS (11), GRID_ROWS (5), MAX_ALIENS (55).
  - typedef pos_t (logic [9:0]).
  - enum march_state_t {IDLE, MARCH, CLEARED, INVADED}.
- One natural sub-module, march_period_gen: combinational alive_count -> period, with the MARCH_SPEEDUP_EN variant inside it.

Test Plan:
- Reset, then enable=1 with alive_count=55, left_edge=0, right_edge=209, feature off, BASE_PERIOD=32. Send 32 frame_ticks -> exactly one step pulse, x_off=2, dir=1.
- Set right_edge=638 with dir=1, then trigger a move event -> drop pulse, y_off=10, dir=0, x_off unchanged, no step.
- Set left_edge=1 with dir=0, then trigger a move event -> drop, dir=1, y_off increments by 10.
- Preload y_off=390, then force a drop -> y_off=400, invaded=1. Further frame_ticks leave all outputs unchanged.
- Drop enable low for 100 frame_ticks mid-count -> outputs and frame_cnt frozen. Motion resumes from the held count when enable returns high.
- Feature on, alive_count 55 -> 1 -> 0: period 32 -> 2 (clamped) -> CLEARED with no step pulses. Assert rst_n low mid-march -> all outputs at reset values immediately.
